// File: rtl/ama_riscv_dmem_access_ctrl.sv
// ama_riscv_dmem_access_ctrl
// Turns one LSU load/store request into one or two aligned word accesses on a
// synchronous DMEM port. It builds the byte write-enable masks and the
// lane-shifted write data. For loads it merges, aligns and sign/zero-extends
// the returned data.
//
// Build option: define DMEM_MISALIGN_SPLIT_EN to split accesses that cross a
// word boundary into two word accesses. When the macro is undefined, such
// requests are rejected with rsp_err and make no memory access.
module ama_riscv_dmem_access_ctrl #(
  parameter int DMEM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [1:0]         req_width,
  input  logic               req_unsigned,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [31:0]        rsp_rdata,
  output logic               mem_en,
  output logic [3:0]         mem_we,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Request fields held for the whole transaction
  logic               r_we;
  logic [DMEM_AW-1:0] r_idx;
  logic [1:0]         r_off;
  logic [1:0]         r_width;
  logic               r_uns;
  logic [31:0]        r_wdata;
  logic               r_err;
`ifdef DMEM_MISALIGN_SPLIT_EN
  logic               r_split;
  logic [31:0]        r_lo_q;
`endif

  logic        w_accept;
  logic [1:0]  w_req_off;
  logic        w_req_split;
  logic        w_req_err;
  logic [3:0]  w_base;
  logic [3:0]  w_mask0;
  logic [31:0] w_wd0;
  logic [63:0] w_r64;
`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [7:0]  w_m8;
  logic [63:0] w_w64;
  logic [3:0]  w_mask1;
  logic [31:0] w_wd1;
`endif

  // Address bits above the DMEM window do not select anything.
  logic w_unused_addr;
  assign w_unused_addr = ^req_addr[31:DMEM_AW+2];

  // Align the selected bytes to bit 0 and extend to 32 bits.
  function automatic logic [31:0] f_load_ext(input logic [63:0] r64,
                                             input logic [1:0]  off,
                                             input logic [1:0]  width,
                                             input logic        uns);
    logic        [31:0] sh;
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    logic        [31:0] res;
    sh  = 32'(r64 >> {off, 3'b000});
    s8  = sh[7:0];
    s16 = sh[15:0];
    case (width)
      2'd0:    res = uns ? {24'd0, sh[7:0]}  : 32'(s8);
      2'd1:    res = uns ? {16'd0, sh[15:0]} : 32'(s16);
      default: res = sh;
    endcase
    return res;
  endfunction

  assign w_accept    = req_valid && (r_state == IDLE);
  assign w_req_off   = req_addr[1:0];
  assign w_req_split = ((req_width == 2'd1) && (w_req_off == 2'd3)) ||
                       ((req_width == 2'd2) && (w_req_off != 2'd0));
`ifdef DMEM_MISALIGN_SPLIT_EN
  assign w_req_err   = (req_width == 2'd3);
`else
  assign w_req_err   = (req_width == 2'd3) || w_req_split;
`endif

  // Byte-lane pattern of the access before it is shifted by the offset.
  always_comb begin
    case (r_width)
      2'd0:    w_base = 4'b0001;
      2'd1:    w_base = 4'b0011;
      default: w_base = 4'b1111;
    endcase
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  assign w_m8    = {4'b0000, w_base} << r_off;
  assign w_mask0 = w_m8[3:0];
  assign w_mask1 = w_m8[7:4];
  assign w_w64   = {32'd0, r_wdata} << {r_off, 3'b000};
  assign w_wd0   = w_w64[31:0];
  assign w_wd1   = w_w64[63:32];
  // The second word arrives in RESP; the first was parked in r_lo_q.
  assign w_r64   = r_split ? {mem_rdata, r_lo_q} : {32'd0, mem_rdata};
`else
  assign w_mask0 = w_base << r_off;
  assign w_wd0   = r_wdata << {r_off, 3'b000};
  assign w_r64   = {32'd0, mem_rdata};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the request on accept
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_idx   <= req_addr[DMEM_AW+1:2];
      r_off   <= w_req_off;
      r_width <= req_width;
      r_uns   <= req_unsigned;
      r_wdata <= req_wdata;
      r_err   <= w_req_err;
`ifdef DMEM_MISALIGN_SPLIT_EN
      r_split <= w_req_split;
`endif
    end
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  // Hold the low word of a split load while the high word is read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo_q <= '0;
    end else if ((r_state == ACC1) && !r_we) begin
      r_lo_q <= mem_rdata;
    end
  end
`endif

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_req_err ? RESP : ACC0;
        end
      end
      ACC0: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
        w_next = r_split ? ACC1 : RESP;
`else
        w_next = RESP;
`endif
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      ACC1:    w_next = RESP;
`endif
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode; every output idles at zero outside the state that drives it
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: req_ready = 1'b1;
      ACC0: begin
        mem_en   = 1'b1;
        mem_addr = r_idx;
        if (r_we) begin
          mem_we    = w_mask0;
          mem_wdata = w_wd0;
        end
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      ACC1: begin
        mem_en   = 1'b1;
        mem_addr = r_idx + DMEM_AW'(1);
        if (r_we) begin
          mem_we    = w_mask1;
          mem_wdata = w_wd1;
        end
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        if (!r_we && !r_err) begin
          rsp_rdata = f_load_ext(w_r64, r_off, r_width, r_uns);
        end
      end
      default: ;
    endcase
  end

endmodule
